// File: rtl/neural_accelerator_if.sv
// Completion bus of the neural accelerator.
// It carries the location and length of the finished result block.
interface neural_accelerator_if;
  logic [7:0] result_base_address;
  logic [7:0] result_word_count;

  modport master (output result_base_address, output result_word_count);
  modport slave  (input  result_base_address, input  result_word_count);
endinterface

// File: rtl/neural_accelerator.sv
// One fully-connected layer with ReLU, driven by a single serial MAC unit.
// Inputs, weights and biases come from a constant ROM image.
module neural_accelerator #(
  parameter int                      N_IN     = 4,
  parameter int                      N_OUT    = 3,
  parameter int                      SHIFT    = 0,
  parameter logic [7:0]              OUT_BASE = 8'h40,
  parameter int                      ACC_W    = 20,
  parameter logic [8*N_IN-1:0]       X_ROM    = {8'h04, 8'h03, 8'h02, 8'h01},
  parameter logic [8*N_IN*N_OUT-1:0] W_ROM    = {8'hFE, 8'hFE, 8'hFE, 8'hFE,
                                                 8'h01, 8'h02, 8'h00, 8'hFF,
                                                 8'h01, 8'h01, 8'h01, 8'h01},
  parameter logic [8*N_OUT-1:0]      B_ROM    = {8'h05, 8'h01, 8'h00}
) (
  input  logic                        clk,
  input  logic                        reset,
  neural_accelerator_if.master        resIf
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, WRITE, DONE} stateType;

  stateType                 r_state;
  stateType                 w_nextState;
  logic [JW-1:0]            r_neuronIdx;
  logic [IW-1:0]            r_inIdx;
  logic signed [ACC_W-1:0]  r_acc;
  logic [7:0]               r_baseAddr;
  logic [7:0]               r_wordCount;
  logic [7:0]               result_mem [N_OUT];

  logic [7:0]               w_xAddr;
  logic [7:0]               w_wAddr;
  logic [7:0]               w_bAddr;
  logic signed [7:0]        w_xData;
  logic signed [7:0]        w_wData;
  logic signed [7:0]        w_bData;
  logic signed [15:0]       w_product;
  logic signed [ACC_W-1:0]  w_shifted;
  logic [7:0]               w_y;
  logic                     w_lastIn;
  logic                     w_lastOut;

  // Combinational ROM: x at 0x00, weights row-major at 0x10, biases at 0x20, zero elsewhere.
  function automatic logic signed [7:0] romRead(input logic [7:0] addr);
    romRead = '0;
    for (int k = 0; k < N_IN; k++)
      if (addr == 8'(k)) romRead = X_ROM[8*k +: 8];
    for (int k = 0; k < N_IN*N_OUT; k++)
      if (addr == 8'(8'h10 + k)) romRead = W_ROM[8*k +: 8];
    for (int k = 0; k < N_OUT; k++)
      if (addr == 8'(8'h20 + k)) romRead = B_ROM[8*k +: 8];
  endfunction

  assign w_xAddr   = 8'(r_inIdx);
  assign w_wAddr   = 8'h10 + 8'(r_neuronIdx) * 8'(N_IN) + 8'(r_inIdx);
  assign w_bAddr   = 8'h20 + 8'(r_neuronIdx);
  assign w_xData   = romRead(w_xAddr);
  assign w_wData   = romRead(w_wAddr);
  assign w_bData   = romRead(w_bAddr);
  assign w_product = w_wData * w_xData;
  assign w_shifted = r_acc >>> SHIFT;
  assign w_lastIn  = (r_inIdx == IW'(N_IN - 1));
  assign w_lastOut = (r_neuronIdx == JW'(N_OUT - 1));

  // ReLU makes the lower saturation bound unreachable, so only the top clamps.
  always_comb begin
    w_y = '0;
    if (w_shifted < 0)
      w_y = 8'h00;
    else if (w_shifted > SAT_MAX)
      w_y = 8'h7F;
    else
      w_y = w_shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = BIAS;
      BIAS:    w_nextState = MAC;
      MAC:     if (w_lastIn) w_nextState = WRITE;
      WRITE:   w_nextState = w_lastOut ? DONE : BIAS;
      DONE:    w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neuronIdx <= '0;
      r_inIdx     <= '0;
      r_acc       <= '0;
      r_baseAddr  <= '0;
      r_wordCount <= '0;
      for (int k = 0; k < N_OUT; k++) result_mem[k] <= '0;
    end else begin
      case (r_state)
        IDLE: r_neuronIdx <= '0;
        BIAS: begin
          r_acc   <= {{(ACC_W-8){w_bData[7]}}, w_bData};
          r_inIdx <= '0;
        end
        MAC: begin
          r_acc   <= r_acc + {{(ACC_W-16){w_product[15]}}, w_product};
          r_inIdx <= r_inIdx + 1'b1;
        end
        WRITE: begin
          result_mem[r_neuronIdx] <= w_y;
          if (!w_lastOut) r_neuronIdx <= r_neuronIdx + 1'b1;
        end
        default: ;
      endcase
      // Outputs become valid on the same edge that enters DONE.
      r_baseAddr  <= (w_nextState == DONE) ? OUT_BASE : 8'h00;
      r_wordCount <= (w_nextState == DONE) ? 8'(N_OUT) : 8'h00;
    end
  end

  assign resIf.result_base_address = r_baseAddr;
  assign resIf.result_word_count   = r_wordCount;

endmodule

// File: tb/tb_neural_accelerator.sv
// Bench for neural_accelerator: default ROM plus a saturating ROM variant,
// with randomized reset aborts checked against an arithmetic layer model.
module tb_neural_accelerator;

  localparam int         N_IN     = 4;
  localparam int         N_OUT    = 3;
  localparam int         SHIFT    = 0;
  localparam logic [7:0] OUT_BASE = 8'h40;
  localparam int         LAT      = 1 + N_OUT * (N_IN + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compareCount = 0;
  int mismatchCount = 0;

  // Reference ROM contents as plain signed integers.
  int xA[N_IN]        = '{1, 2, 3, 4};
  int wA[N_OUT][N_IN] = '{'{1, 1, 1, 1}, '{-1, 0, 2, 1}, '{-2, -2, -2, -2}};
  int bA[N_OUT]       = '{0, 1, 5};
  int xS[N_IN]        = '{127, 127, 127, 127};
  int wS[N_OUT][N_IN] = '{'{127, 127, 127, 127}, '{-1, 0, 2, 1}, '{-2, -2, -2, -2}};
  int bS[N_OUT]       = '{0, 1, 5};

  neural_accelerator_if ifA ();
  neural_accelerator_if ifS ();

  neural_accelerator #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT), .OUT_BASE(OUT_BASE), .ACC_W(20)
  ) dutA (
    .clk(clk), .reset(reset), .resIf(ifA)
  );

  neural_accelerator #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT), .OUT_BASE(OUT_BASE), .ACC_W(20),
    .X_ROM({8'h7F, 8'h7F, 8'h7F, 8'h7F}),
    .W_ROM({8'hFE, 8'hFE, 8'hFE, 8'hFE,
            8'h01, 8'h02, 8'h00, 8'hFF,
            8'h7F, 8'h7F, 8'h7F, 8'h7F}),
    .B_ROM({8'h05, 8'h01, 8'h00})
  ) dutS (
    .clk(clk), .reset(reset), .resIf(ifS)
  );

  always #2 clk = ~clk;

  // Layer model: y = relu(sat8((b + sum w*x) >>> SHIFT)).
  function automatic int refNeuron(input bit useSat, input int j);
    int acc;
    acc = useSat ? bS[j] : bA[j];
    for (int i = 0; i < N_IN; i++)
      acc += useSat ? wS[j][i] * xS[i] : wA[j][i] * xA[i];
    acc = acc >>> SHIFT;
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
    if (acc < 0)    acc = 0;
    return acc;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive reset at the falling edge and let the given number of rising edges pass.
  task automatic applyStimulus(input logic rst, input int edges);
    reset = rst;
    repeat (edges) @(negedge clk);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " A base"},  int'(ifA.result_base_address), 0);
    checkOutput({tag, " A count"}, int'(ifA.result_word_count),   0);
    checkOutput({tag, " S base"},  int'(ifS.result_base_address), 0);
    checkOutput({tag, " S count"}, int'(ifS.result_word_count),   0);
  endtask

  task automatic checkDoneOutputs(input string tag);
    checkOutput({tag, " A base"},  int'(ifA.result_base_address), int'(OUT_BASE));
    checkOutput({tag, " A count"}, int'(ifA.result_word_count),   N_OUT);
    checkOutput({tag, " S base"},  int'(ifS.result_base_address), int'(OUT_BASE));
    checkOutput({tag, " S count"}, int'(ifS.result_word_count),   N_OUT);
  endtask

  task automatic checkResults(input string tag, input bit cleared);
    for (int j = 0; j < N_OUT; j++) begin
      checkOutput($sformatf("%s A mem[%0d]", tag, j), int'(dutA.result_mem[j]),
                  cleared ? 0 : refNeuron(1'b0, j));
      checkOutput($sformatf("%s S mem[%0d]", tag, j), int'(dutS.result_mem[j]),
                  cleared ? 0 : refNeuron(1'b1, j));
    end
  endtask

  // Release reset and check outputs on every edge up to and including DONE entry.
  task automatic runToDone(input string tag);
    reset = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      @(negedge clk);
      if (e < LAT) checkIdleOutputs($sformatf("%s edge%0d", tag, e));
      else         checkDoneOutputs($sformatf("%s done", tag));
    end
    checkResults(tag, 1'b0);
  endtask

  initial begin
    int abortEdge;
    int holdLen;

    $display("[TB] neural_accelerator bench, expected latency %0d edges", LAT);
    reset = 1'b1;
    @(negedge clk);
    checkIdleOutputs("reset");
    checkResults("reset", 1'b1);

    runToDone("run1");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 10);
      checkDoneOutputs($sformatf("hold%0d", k));
    end
    checkResults("hold", 1'b0);

    // Reset while in DONE clears outputs and results on the very next edge.
    applyStimulus(1'b1, 1);
    checkIdleOutputs("resetInDone");
    checkResults("resetInDone", 1'b1);

    // Abort at edge 10 for two cycles, then restart.
    applyStimulus(1'b0, 9);
    applyStimulus(1'b1, 2);
    checkIdleOutputs("abort10");
    checkResults("abort10", 1'b1);
    runToDone("after10");

    for (int r = 0; r < 4; r++) begin
      abortEdge = int'($urandom_range(2, LAT - 1));
      holdLen   = int'($urandom_range(1, 4));
      applyStimulus(1'b1, 1);
      applyStimulus(1'b0, abortEdge - 1);
      applyStimulus(1'b1, holdLen);
      checkIdleOutputs($sformatf("rndAbort%0d", r));
      checkResults($sformatf("rndAbort%0d", r), 1'b1);
      runToDone($sformatf("rndRun%0d", r));
    end

    // Long reset keeps everything at zero.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 5);
      checkIdleOutputs($sformatf("longReset%0d", k));
    end
    checkResults("longReset", 1'b1);
    runToDone("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
